cash_dispense_ctrl: RTL and testbench

// - Receiving end of the ATM withdrawal request: accepts an amount from the transaction FSM over valid/ready,

---
 rtl/atm_pkg.sv | 24 ++
 rtl/cash_dispense_ctrl_note_pick.sv | 30 +++
 rtl/cash_dispense_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cash_dispense_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and constants for the cash dispense controller
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPENSE,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [1:0] SEL_100 = 2'b00;
  localparam logic [1:0] SEL_200 = 2'b01;
  localparam logic [1:0] SEL_500 = 2'b10;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_INVALID = 2'b01;
  localparam logic [1:0] STAT_INSUFF  = 2'b10;

  localparam int DENOM_500 = 500;
  localparam int DENOM_200 = 200;
  localparam int DENOM_100 = 100;

endpackage

// File: rtl/cash_dispense_ctrl_note_pick.sv
// rtl/cash_dispense_ctrl_note_pick.sv - combinational greedy note picker
module note_pick
  import atm_pkg::*;
#(
  parameter int AMT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic [AMT_W-1:0] rem_i,
  input  logic [CNT_W-1:0] c500_i,
  input  logic [CNT_W-1:0] c200_i,
  input  logic [CNT_W-1:0] c100_i,
  output logic [1:0]       sel_o,
  output logic             valid_o
);

  always_comb begin
    sel_o   = SEL_100;
    valid_o = 1'b1;
    if (rem_i >= AMT_W'(DENOM_500) && c500_i != '0) begin
      sel_o = SEL_500;
    end else if (rem_i >= AMT_W'(DENOM_200) && c200_i != '0) begin
      sel_o = SEL_200;
    end else if (rem_i >= AMT_W'(DENOM_100) && c100_i != '0) begin
      sel_o = SEL_100;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/cash_dispense_ctrl.sv
// rtl/cash_dispense_ctrl.sv - all-or-nothing ATM note dispense controller
module cash_dispense_ctrl
  import atm_pkg::*;
#(
  parameter int AMT_W    = 16,
  parameter int CNT_W    = 8,
  parameter int INIT_500 = 20,
  parameter int INIT_200 = 20,
  parameter int INIT_100 = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             mech_busy,
  input  logic             refill,
  output logic             note_pulse,
  output logic [1:0]       note_sel,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] inv_500,
  output logic [CNT_W-1:0] inv_200,
  output logic [CNT_W-1:0] inv_100
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d, sh_rem_q, sh_rem_d;
  logic [CNT_W-1:0] inv500_q, inv500_d, inv200_q, inv200_d, inv100_q, inv100_d;
  logic [CNT_W-1:0] sh500_q, sh500_d, sh200_q, sh200_d, sh100_q, sh100_d;
  logic             pulse_q, pulse_d;
  logic [1:0]       sel_q, sel_d, status_q, status_d;

  logic             in_check, pk_valid;
  logic [1:0]       pk_sel;
  logic [AMT_W-1:0] pk_amt;

  // One picker serves both the dry-run (shadow) and the real dispense pass.
  assign in_check = (state_q == ST_CHECK);

  note_pick #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_pick (
    .rem_i   (in_check ? sh_rem_q : rem_q),
    .c500_i  (in_check ? sh500_q  : inv500_q),
    .c200_i  (in_check ? sh200_q  : inv200_q),
    .c100_i  (in_check ? sh100_q  : inv100_q),
    .sel_o   (pk_sel),
    .valid_o (pk_valid)
  );

  always_comb begin
    case (pk_sel)
      SEL_500: pk_amt = AMT_W'(DENOM_500);
      SEL_200: pk_amt = AMT_W'(DENOM_200);
      default: pk_amt = AMT_W'(DENOM_100);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sh_rem_d = sh_rem_q;
    inv500_d = inv500_q;
    inv200_d = inv200_q;
    inv100_d = inv100_q;
    sh500_d  = sh500_q;
    sh200_d  = sh200_q;
    sh100_d  = sh100_q;
    pulse_d  = 1'b0;
    sel_d    = sel_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d    = req_amount;
          sh_rem_d = req_amount;
          if (req_amount == '0 || (req_amount % AMT_W'(DENOM_100)) != '0) begin
            status_d = STAT_INVALID;
            state_d  = ST_DONE;
          end else begin
            sh500_d = inv500_q;
            sh200_d = inv200_q;
            sh100_d = inv100_q;
            state_d = ST_CHECK;
          end
        end else if (refill) begin
          inv500_d = CNT_W'(INIT_500);
          inv200_d = CNT_W'(INIT_200);
          inv100_d = CNT_W'(INIT_100);
        end
      end
      ST_CHECK: begin
        if (sh_rem_q == '0) begin
          state_d = ST_DISPENSE;
        end else if (pk_valid) begin
          sh_rem_d = sh_rem_q - pk_amt;
          case (pk_sel)
            SEL_500: sh500_d = sh500_q - 1'b1;
            SEL_200: sh200_d = sh200_q - 1'b1;
            default: sh100_d = sh100_q - 1'b1;
          endcase
        end else begin
          status_d = STAT_INSUFF;
          state_d  = ST_DONE;
        end
      end
      ST_DISPENSE: begin
        if (!mech_busy) begin
          if (pk_valid) begin
            pulse_d = 1'b1;
            sel_d   = pk_sel;
            rem_d   = rem_q - pk_amt;
            case (pk_sel)
              SEL_500: inv500_d = inv500_q - 1'b1;
              SEL_200: inv200_d = inv200_q - 1'b1;
              default: inv100_d = inv100_q - 1'b1;
            endcase
            state_d = ST_GAP;
          end else begin
            status_d = STAT_INSUFF;
            state_d  = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (rem_q == '0) begin
          status_d = STAT_OK;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_DISPENSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      sh_rem_q <= '0;
      inv500_q <= CNT_W'(INIT_500);
      inv200_q <= CNT_W'(INIT_200);
      inv100_q <= CNT_W'(INIT_100);
      sh500_q  <= '0;
      sh200_q  <= '0;
      sh100_q  <= '0;
      pulse_q  <= 1'b0;
      sel_q    <= SEL_100;
      status_q <= STAT_OK;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      sh_rem_q <= sh_rem_d;
      inv500_q <= inv500_d;
      inv200_q <= inv200_d;
      inv100_q <= inv100_d;
      sh500_q  <= sh500_d;
      sh200_q  <= sh200_d;
      sh100_q  <= sh100_d;
      pulse_q  <= pulse_d;
      sel_q    <= sel_d;
      status_q <= status_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign note_pulse = pulse_q;
  assign note_sel   = sel_q;
  assign status     = status_q;
  assign inv_500    = inv500_q;
  assign inv_200    = inv200_q;
  assign inv_100    = inv100_q;

endmodule

// File: tb/tb_cash_dispense_ctrl.sv
// tb/tb_cash_dispense_ctrl.sv - self-checking bench for cash_dispense_ctrl
module tb_cash_dispense_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_amount;
  logic        req_ready;
  logic        mech_busy;
  logic        refill;
  logic        note_pulse;
  logic [1:0]  note_sel;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  inv_500, inv_200, inv_100;

  int tests = 0;
  int fails = 0;
  int m500, m200, m100;

  cash_dispense_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .mech_busy  (mech_busy),
    .refill     (refill),
    .note_pulse (note_pulse),
    .note_sel   (note_sel),
    .done       (done),
    .status     (status),
    .inv_500    (inv_500),
    .inv_200    (inv_200),
    .inv_100    (inv_100)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    chk({tag, "_inv500"}, 32'(inv_500), 32'(m500));
    chk({tag, "_inv200"}, 32'(inv_200), 32'(m200));
    chk({tag, "_inv100"}, 32'(inv_100), 32'(m100));
  endtask

  task automatic model_init();
    m500 = 20;
    m200 = 20;
    m100 = 40;
  endtask

  // Outcome of a request computed from counts: how many of each note fit, largest first.
  task automatic model(input int amt, output int st, output int n5, output int n2,
                       output int n1, output int exp_lat);
    int r;
    n5 = 0; n2 = 0; n1 = 0;
    if (amt == 0 || amt % 100 != 0) begin
      st = 1;
      exp_lat = 1;
    end else begin
      r  = amt;
      n5 = (r / 500 < m500) ? r / 500 : m500;
      r -= 500 * n5;
      n2 = (r / 200 < m200) ? r / 200 : m200;
      r -= 200 * n2;
      n1 = (r / 100 < m100) ? r / 100 : m100;
      r -= 100 * n1;
      if (r != 0) begin
        st = 2;
        exp_lat = n5 + n2 + n1 + 2;
        n5 = 0; n2 = 0; n1 = 0;
      end else begin
        st = 0;
        exp_lat = 3 * (n5 + n2 + n1) + 2;
      end
    end
  endtask

  task automatic do_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    model_init();
    check_inv("refill");
  endtask

  // busy_mode: 0 never busy, 1 random busy, 2 busy for the first 5 cycles after accept
  task automatic do_req(input int amt, input int busy_mode, input bit poke,
                        input bit rst_after_first, input bit refill_at_accept);
    int st, n5, n2, n1, exp_lat, lat, npulse, last_pulse, busy_left, poke_left, es;
    int exp_sel[$];
    bit fin;
    model(amt, st, n5, n2, n1, exp_lat);
    exp_sel = {};
    for (int i = 0; i < n5; i++) exp_sel.push_back(2);
    for (int i = 0; i < n2; i++) exp_sel.push_back(1);
    for (int i = 0; i < n1; i++) exp_sel.push_back(0);

    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 1);
    req_amount = 16'(amt);
    req_valid  = 1'b1;
    refill     = refill_at_accept;
    mech_busy  = (busy_mode == 2);
    busy_left  = 5;
    @(posedge clk);
    lat = 0; npulse = 0; last_pulse = -10; poke_left = 0; fin = 1'b0;
    while (!fin && lat < 400) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      refill    = 1'b0;
      if (note_pulse) begin
        chk("busy_low_at_pulse", 32'(mech_busy), 0);
        chk("pulse_spacing", 32'(lat - last_pulse >= 2), 1);
        es = (npulse < exp_sel.size()) ? exp_sel[npulse] : 3;
        chk("pulse_sel", 32'(note_sel), 32'(es));
        if (es == 2) m500--;
        else if (es == 1) m200--;
        else if (es == 0) m100--;
        last_pulse = lat;
        npulse++;
        if (poke && npulse == 1) poke_left = 3;
        if (rst_after_first) begin
          rst = 1'b1;
          #1;
          model_init();
          chk("rst_pulse", 32'(note_pulse), 0);
          chk("rst_sel", 32'(note_sel), 0);
          chk("rst_done", 32'(done), 0);
          chk("rst_status", 32'(status), 0);
          chk("rst_ready", 32'(req_ready), 1);
          check_inv("rst_mid");
          @(negedge clk);
          rst = 1'b0;
          fin = 1'b1;
        end
      end
      if (done && !fin) begin
        chk("status", 32'(status), 32'(st));
        chk("pulse_count", 32'(npulse), 32'(exp_sel.size()));
        if (busy_mode == 0) chk("latency", 32'(lat), 32'(exp_lat));
        fin = 1'b1;
      end
      if (poke_left > 0) begin
        chk("ready_low_dispense", 32'(req_ready), 0);
        req_valid  = 1'b1;
        req_amount = 16'd100;
        refill     = 1'b1;
        poke_left--;
      end
      if (busy_mode == 1) begin
        mech_busy = ($urandom_range(0, 2) == 0);
      end else if (busy_mode == 2) begin
        if (busy_left > 0) busy_left--;
        mech_busy = (busy_left > 0);
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    mech_busy = 1'b0;
    req_valid = 1'b0;
    refill    = 1'b0;
    if (!rst_after_first) check_inv("after_req");
  endtask

  initial begin
    int amt;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_amount = '0;
    mech_busy  = 1'b0;
    refill     = 1'b0;
    model_init();
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 1);
    chk("reset_pulse", 32'(note_pulse), 0);
    chk("reset_sel", 32'(note_sel), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_status", 32'(status), 0);
    check_inv("reset");
    rst = 1'b0;
    @(negedge clk);

    do_req(800, 0, 0, 0, 0);
    chk("after800_inv500", 32'(inv_500), 19);
    chk("after800_inv100", 32'(inv_100), 39);
    do_req(250, 0, 0, 0, 0);
    do_req(0, 0, 0, 0, 0);

    do_refill();
    do_req(9500, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) do_req(400, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) do_req(300, 0, 0, 0, 0);
    do_req(100, 0, 0, 0, 0);
    check_inv("drained");
    do_req(600, 0, 0, 0, 0);
    chk("insuff_status", 32'(status), 2);
    do_refill();

    do_req(500, 2, 0, 0, 0);
    do_req(800, 0, 1, 0, 0);
    do_req(1500, 0, 0, 1, 0);

    for (int k = 0; k < 25; k++) begin
      amt = $urandom_range(0, 30) * 100;
      if ($urandom_range(0, 4) == 0) amt += $urandom_range(1, 99);
      do_req(amt, 1, 0, 0, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 5) == 0) do_refill();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
